keypad_emu: RTL and testbench

KEYPAD_EMU -- requirements
Module: keypad_emu

---
 rtl/keypad_pkg.sv | 32 +++
 rtl/keypad_emu_bounce_timer.sv | 38 +++
 rtl/keypad_emu.sv | 183 ++++++++++++++++++
 tb/tb_keypad_emu.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the keypad emulator: the sequencer state encoding,
// the parameter defaults, the interval-timer width and the mapping from a
// 4-bit key index to the row line it drives and the column line it senses.
package keypad_pkg;

    localparam int DEF_BOUNCE_CYC = 8;
    localparam int DEF_NUM_BOUNCE = 4;
    localparam int DEF_GAP_CYC    = 16;

    // Interval timer width; it must hold the largest hold count (16 bits).
    localparam int TMR_W = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS_BNC = 3'd1,
        HOLD      = 3'd2,
        REL_BNC   = 3'd3,
        GAP       = 3'd4
    } state_t;

    // key[3:2] selects the row line that is pulled by the switch.
    function automatic logic [1:0] key_row(input logic [3:0] key);
        return key[3:2];
    endfunction

    // key[1:0] selects the column drive line that is copied onto that row.
    function automatic logic [1:0] key_col(input logic [3:0] key);
        return key[1:0];
    endfunction

endpackage

// File: rtl/keypad_emu_bounce_timer.sv
// bounce_timer
// Loadable down counter used for every timed interval of the keypad emulator
// (bounce half-periods, stable hold and post-release gap).
// Loading value N-1 makes expire rise in the N-th cycle after the load edge,
// so an interval loaded with N-1 lasts exactly N cycles.
// Ports:
//   clk      - system clock
//   rst      - asynchronous active-high reset, clears the count
//   load     - load load_val on the next rising edge (has priority)
//   load_val - value to load
//   expire   - count has reached zero (current interval ends this cycle)
module bounce_timer
    import keypad_pkg::*;
#(
    parameter int WIDTH = TMR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expire
);

    logic [WIDTH-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign expire = (cnt_reg == '0);

endmodule

// File: rtl/keypad_emu.sv
// keypad_emu
// Emulates one switch of a 4x4 matrix keypad pressed by command: contact
// bounce on press, a stable closed hold, bounce on release and an open gap,
// then a one-cycle done pulse. While the contact is closed the selected row
// line follows the selected column drive combinationally.
// Ports:
//   clk       - system clock
//   rst       - asynchronous active-high reset
//   cmd_valid - press command present
//   cmd_ready - emulator idle; command taken on cmd_valid & cmd_ready
//   cmd_key   - key index (row group key[3:2], column key[1:0])
//   cmd_hold  - stable-closed cycles (0 behaves as 1)
//   col       - active-low column drive from the scanner
//   row       - row sense back to the scanner
//   contact   - emulated switch closed
//   busy      - command in progress
//   done      - one-cycle pulse at the end of a sequence
module keypad_emu
    import keypad_pkg::*;
#(
    parameter int BOUNCE_CYC = DEF_BOUNCE_CYC,
    parameter int NUM_BOUNCE = DEF_NUM_BOUNCE,
    parameter int GAP_CYC    = DEF_GAP_CYC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_key,
    input  logic [15:0] cmd_hold,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic        contact,
    output logic        busy,
    output logic        done
);

    localparam logic [TMR_W-1:0] BNC_LOAD = TMR_W'(BOUNCE_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYC - 1);
    localparam logic [15:0]      LAST_PAIR = 16'(NUM_BOUNCE - 1);

    state_t             state_reg, state_next;
    logic [3:0]         key_reg;
    logic [15:0]        hold_reg;
    // half_reg: 0 = first half of a bounce pair, 1 = second half
    logic               half_reg, half_next;
    logic [15:0]        pair_reg, pair_next;
    logic               done_reg;
    logic               accept;
    logic [15:0]        hold_eff;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_expire;
    logic               contact_int;

    assign accept   = cmd_valid && (state_reg == IDLE);
    assign hold_eff = (cmd_hold == 16'd0) ? 16'd1 : cmd_hold;

    bounce_timer #(
        .WIDTH(TMR_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .load_val(tmr_val),
        .expire  (tmr_expire)
    );

    // State register plus the data latched at acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            half_reg  <= 1'b0;
            pair_reg  <= '0;
            key_reg   <= '0;
            hold_reg  <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            half_reg  <= half_next;
            pair_reg  <= pair_next;
            // done is high in the first IDLE cycle after the gap expires
            done_reg  <= (state_reg == GAP) && tmr_expire;
            if (accept) begin
                key_reg  <= cmd_key;
                hold_reg <= hold_eff;
            end
        end
    end

    // Next-state logic; every phase change reloads the timer with the
    // length of the phase being entered.
    always_comb begin
        state_next = state_reg;
        half_next  = half_reg;
        pair_next  = pair_reg;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    tmr_load  = 1'b1;
                    half_next = 1'b0;
                    pair_next = '0;
                    if (NUM_BOUNCE == 0) begin
                        state_next = HOLD;
                        tmr_val    = hold_eff - 16'd1;
                    end else begin
                        state_next = PRESS_BNC;
                        tmr_val    = BNC_LOAD;
                    end
                end
            end
            PRESS_BNC, REL_BNC: begin
                if (tmr_expire) begin
                    tmr_load = 1'b1;
                    if (half_reg && (pair_reg == LAST_PAIR)) begin
                        half_next = 1'b0;
                        pair_next = '0;
                        if (state_reg == PRESS_BNC) begin
                            state_next = HOLD;
                            tmr_val    = hold_reg - 16'd1;
                        end else begin
                            state_next = GAP;
                            tmr_val    = GAP_LOAD;
                        end
                    end else begin
                        half_next = ~half_reg;
                        tmr_val   = BNC_LOAD;
                        if (half_reg) begin
                            pair_next = pair_reg + 16'd1;
                        end
                    end
                end
            end
            HOLD: begin
                if (tmr_expire) begin
                    tmr_load = 1'b1;
                    if (NUM_BOUNCE == 0) begin
                        state_next = GAP;
                        tmr_val    = GAP_LOAD;
                    end else begin
                        state_next = REL_BNC;
                        tmr_val    = BNC_LOAD;
                    end
                end
            end
            GAP: begin
                if (tmr_expire) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decoded from the state. Press bounce starts closed, release
    // bounce starts open.
    always_comb begin
        contact_int = 1'b0;
        cmd_ready   = 1'b0;
        case (state_reg)
            IDLE:      cmd_ready   = 1'b1;
            PRESS_BNC: contact_int = ~half_reg;
            HOLD:      contact_int = 1'b1;
            REL_BNC:   contact_int = half_reg;
            default:   contact_int = 1'b0;
        endcase
    end

    assign contact = contact_int;
    assign busy    = ~cmd_ready;
    assign done    = done_reg;

    // Only the latched key's row follows its column, and only while closed.
    for (genvar gi = 0; gi < 4; gi++) begin : g_row
        assign row[gi] = (contact_int && (key_row(key_reg) == 2'(gi)))
                         ? col[key_col(key_reg)] : 1'b1;
    end

endmodule

// File: tb/tb_keypad_emu.sv
module tb_keypad_emu;
    import keypad_pkg::*;

    localparam int BC = DEF_BOUNCE_CYC;
    localparam int NB = DEF_NUM_BOUNCE;
    localparam int GC = DEF_GAP_CYC;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [3:0]  cmd_key;
    logic [15:0] cmd_hold;
    bit          dut_sel;
    logic [3:0]  col_drv;
    logic [3:0]  scan_col;
    bit          scan_en;
    logic [3:0]  col_a;

    logic        cmd_valid_a, cmd_ready_a, contact_a, busy_a, done_a;
    logic        cmd_valid_b, cmd_ready_b, contact_b, busy_b, done_b;
    logic [3:0]  row_a, row_b;

    logic        rdy_s, contact_s, busy_s, done_s;
    logic [3:0]  row_s, col_s;

    int checks = 0;
    int errors = 0;
    int scan_flags = 0;
    int scan_data = -1;

    assign cmd_valid_a = cmd_valid & ~dut_sel;
    assign cmd_valid_b = cmd_valid & dut_sel;
    assign col_a       = scan_en ? scan_col : col_drv;

    assign rdy_s     = dut_sel ? cmd_ready_b : cmd_ready_a;
    assign contact_s = dut_sel ? contact_b : contact_a;
    assign busy_s    = dut_sel ? busy_b : busy_a;
    assign done_s    = dut_sel ? done_b : done_a;
    assign row_s     = dut_sel ? row_b : row_a;
    assign col_s     = dut_sel ? col_drv : col_a;

    keypad_emu u_dut_a (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
        .cmd_key(cmd_key), .cmd_hold(cmd_hold), .col(col_a), .row(row_a),
        .contact(contact_a), .busy(busy_a), .done(done_a)
    );

    keypad_emu #(.NUM_BOUNCE(0)) u_dut_b (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
        .cmd_key(cmd_key), .cmd_hold(cmd_hold), .col(col_drv), .row(row_b),
        .contact(contact_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    // Contact level t cycles after acceptance, straight from the phase rules.
    function automatic bit exp_contact(int t, int nb, int he);
        int bl;
        int u;
        bl = 2 * nb * BC;
        u  = t;
        if (u < bl) return ((u / BC) % 2) == 0;
        u -= bl;
        if (u < he) return 1'b1;
        u -= he;
        if (u < bl) return ((u / BC) % 2) == 1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] exp_row(bit c, int key, logic [3:0] cv);
        logic [3:0] r;
        r = 4'hF;
        if (c) r[key / 4] = cv[key % 4];
        return r;
    endfunction

    // Issue one command at the current falling edge and follow it to done.
    // chaos keeps cmd_valid high and scrambles key/hold while busy.
    task automatic run_seq(input bit sel, input logic [3:0] key, input logic [15:0] hold,
                           input bit chaos, output int done_t);
        int nb, he, total, bad, first_bad;
        bit ec;
        nb = sel ? 0 : NB;
        he = (hold == 16'd0) ? 1 : int'(hold);
        total = 4 * nb * BC + he + GC;
        bad = 0;
        first_bad = -1;
        done_t = -1;
        dut_sel = sel;
        cmd_key = key;
        cmd_hold = hold;
        cmd_valid = 1'b1;
        chk("ready_at_issue", 32'(rdy_s), 32'd1);
        @(negedge clk);
        for (int t = 0; t <= total + 4; t++) begin
            if (t > 0) @(negedge clk);
            ec = exp_contact(t, nb, he);
            if (contact_s !== ec || row_s !== exp_row(ec, int'(key), col_s) ||
                busy_s !== (t < total) || rdy_s !== (t >= total)) begin
                bad++;
                if (first_bad < 0) first_bad = t;
            end
            if (done_s === 1'b1) begin
                done_t = t;
                break;
            end
            if (!chaos) cmd_valid = 1'b0;
            if (!scan_en) col_drv = 4'($urandom);
            if (chaos) begin
                cmd_key = 4'($urandom);
                cmd_hold = 16'($urandom);
            end
        end
        chk("seq_waveform_bad_cycles", 32'(bad), 32'd0);
        chk("seq_done_cycle", 32'(done_t), 32'(total));
        $display("seq dut=%0d key=%0d hold=%0d chaos=%0d done_at=%0d want=%0d bad=%0d first_bad=%0d",
                 sel, key, hold, chaos, done_t, total, bad, first_bad);
    endtask

    // Behavioural matrix scanner: one active-low column per 4 cycles, a key
    // is registered after 3 identical frames and released after 3 empty ones.
    initial begin : scanner
        int frame_key, last_key, stable_cnt, empty_cnt;
        bit pressed;
        last_key = -1;
        stable_cnt = 0;
        empty_cnt = 0;
        pressed = 1'b0;
        scan_col = 4'hF;
        forever begin
            if (!scan_en) begin
                @(posedge clk);
                last_key = -1;
                stable_cnt = 0;
                empty_cnt = 0;
                pressed = 1'b0;
            end else begin
                frame_key = -1;
                for (int c = 0; c < 4; c++) begin
                    @(posedge clk);
                    scan_col = ~(4'b0001 << c);
                    for (int k = 0; k < 4; k++) begin
                        @(negedge clk);
                        for (int r = 0; r < 4; r++)
                            if (row_a[r] == 1'b0) frame_key = r * 4 + c;
                    end
                end
                if (frame_key >= 0) begin
                    empty_cnt = 0;
                    stable_cnt = (frame_key == last_key) ? stable_cnt + 1 : 1;
                end else begin
                    stable_cnt = 0;
                    empty_cnt++;
                end
                last_key = frame_key;
                if (!pressed && stable_cnt >= 3) begin
                    pressed = 1'b1;
                    scan_flags++;
                    scan_data = frame_key;
                end else if (pressed && empty_cnt >= 3) begin
                    pressed = 1'b0;
                end
            end
        end
    end

    initial begin : stim
        int done_t, n, f0, tmp, j;
        int order[16];
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_key = 4'd0;
        cmd_hold = 16'd0;
        dut_sel = 1'b0;
        col_drv = 4'hF;
        scan_en = 1'b0;

        // Reset state
        #7;
        chk("rst_ready_a", 32'(cmd_ready_a), 32'd1);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_done_a", 32'(done_a), 32'd0);
        chk("rst_contact_a", 32'(contact_a), 32'd0);
        chk("rst_row_a", 32'(row_a), 32'hF);
        chk("rst_ready_b", 32'(cmd_ready_b), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Default timing, key 1 hold 100
        run_seq(1'b0, 4'd1, 16'd100, 1'b0, done_t);
        chk("done_at_244", 32'(done_t), 32'd244);
        @(negedge clk);
        chk("done_one_cycle", 32'(done_a), 32'd0);

        // Random commands on the bouncing emulator
        repeat (3) run_seq(1'b0, 4'($urandom), 16'($urandom_range(1, 300)), 1'b0, done_t);

        // Row mapping for key 14
        dut_sel = 1'b0;
        cmd_key = 4'd14;
        cmd_hold = 16'd100;
        col_drv = 4'hF;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (70) @(negedge clk);
        col_drv = 4'b1011;
        @(negedge clk);
        chk("k14_contact_hold", 32'(contact_a), 32'd1);
        chk("k14_row_col1011", 32'(row_a), 32'b0111);
        col_drv = 4'b1101;
        @(negedge clk);
        chk("k14_row_col1101", 32'(row_a), 32'b1111);
        n = 0;
        while (done_a !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("k14_done_seen", 32'(done_a), 32'd1);
        for (int i = 0; i < 16; i++) begin
            col_drv = 4'(i);
            @(negedge clk);
            chk("k14_row_open", 32'(row_a), 32'hF);
        end

        // cmd_valid held with scrambled inputs, next command taken at done
        run_seq(1'b0, 4'($urandom), 16'($urandom_range(20, 120)), 1'b1, done_t);
        run_seq(1'b0, 4'($urandom), 16'($urandom_range(20, 120)), 1'b0, done_t);

        // Reset in the middle of HOLD
        dut_sel = 1'b0;
        cmd_key = 4'd7;
        cmd_hold = 16'd200;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (80) @(negedge clk);
        chk("pre_rst_contact", 32'(contact_a), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_row", 32'(row_a), 32'hF);
        chk("midrst_ready", 32'(cmd_ready_a), 32'd1);
        chk("midrst_contact", 32'(contact_a), 32'd0);
        chk("midrst_busy", 32'(busy_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (400) begin
            @(negedge clk);
            if (done_a === 1'b1) n++;
        end
        chk("midrst_no_done", 32'(n), 32'd0);
        run_seq(1'b0, 4'($urandom), 16'($urandom_range(1, 60)), 1'b0, done_t);

        // No-bounce build, hold 0 behaves as 1
        run_seq(1'b1, 4'd5, 16'd0, 1'b0, done_t);
        chk("nb0_done_at_17", 32'(done_t), 32'(GC + 1));
        repeat (2) run_seq(1'b1, 4'($urandom), 16'($urandom_range(0, 40)), 1'b0, done_t);

        // All 16 keys through the scanner, legends 1 + 9 = first
        order[0] = 8; order[1] = 15; order[2] = 2; order[3] = 14;
        j = 4;
        for (int k = 0; k < 16; k++)
            if (k != 8 && k != 15 && k != 2 && k != 14) begin
                order[j] = k;
                j++;
            end
        for (int k = 15; k > 4; k--) begin
            j = 4 + int'($urandom_range(0, k - 4));
            tmp = order[k];
            order[k] = order[j];
            order[j] = tmp;
        end
        scan_en = 1'b1;
        repeat (48) @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            f0 = scan_flags;
            run_seq(1'b0, 4'(order[k]), 16'($urandom_range(150, 250)), 1'b0, done_t);
            repeat (80) @(negedge clk);
            chk("scan_flag_count", 32'(scan_flags - f0), 32'd1);
            chk("scan_data", 32'(scan_data), 32'(order[k]));
            $display("scan key=%0d flags=%0d data=%0d", order[k], scan_flags - f0, scan_data);
        end
        scan_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
